// File: rtl/mips_pkg.sv
// ============================================================================
//  Module  : mips_pkg
//  Brief   : Shared state encodings, opcodes, ALUOp codes and control word
//            for the multicycle MIPS controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR = 2'b01;
  localparam logic [1:0] C_SRCB_IMM  = 2'b10;
  localparam logic [1:0] C_SRCB_IMM4 = 2'b11;

  localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_mc_outdec.sv
// ============================================================================
//  Module  : mips_mc_outdec
//  Brief   : Moore output decoder, state -> control word.
//            JUMP state decoded only when MIPS_MC_JUMP_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.alusrcb = C_SRCB_FOUR;
        o_ctrl.aluop   = C_ALUOP_ADD;
        o_ctrl.pcsrc   = C_PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = C_SRCB_IMM4;
        o_ctrl.aluop   = C_ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = C_SRCB_IMM;
        o_ctrl.aluop   = C_ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = C_SRCB_REG;
        o_ctrl.aluop   = C_ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = C_SRCB_REG;
        o_ctrl.aluop   = C_ALUOP_SUB;
        o_ctrl.pcsrc   = C_PCSRC_ALUOUT;
        o_ctrl.branch  = 1'b1;
      end
      S_ADDIWB: begin
        o_ctrl.regwrite = 1'b1;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.pcsrc   = C_PCSRC_JUMP;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_control.sv
// ============================================================================
//  Module  : mips_mc_control
//  Brief   : Multicycle MIPS Moore controller; j supported only when
//            MIPS_MC_JUMP_EN is defined, otherwise it is an illegal opcode.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_EXECUTE;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
          C_OP_J:           w_next = S_JUMP;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  w_next = (Op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Write enables are gated by reset so an aborted instruction commits nothing.
  assign IorD      = w_ctrl.iord;
  assign MemWrite  = w_ctrl.memwrite & ~reset;
  assign IRWrite   = w_ctrl.irwrite  & ~reset;
  assign RegWrite  = w_ctrl.regwrite & ~reset;
  assign RegDst    = w_ctrl.regdst;
  assign MemtoReg  = w_ctrl.memtoreg;
  assign ALUSrcA   = w_ctrl.alusrca;
  assign ALUSrcB   = w_ctrl.alusrcb;
  assign ALUOp     = w_ctrl.aluop;
  assign PCSrc     = w_ctrl.pcsrc;
  assign PCEn      = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & Zero));
  assign IllegalOp = ~reset & w_illegal;
  assign State     = r_state;

endmodule

`default_nettype wire
